sha256_msg_schedule: RTL and testbench

- SHA-256 message-schedule stage. Accepts one 512-bit padded message block and streams the 64 schedule words W[0..63] to the downstream compression-round stage, one word per handshake.
- Holds a 16-word sliding window. W[16..63] are produced by the team's existing SHA256_New_W expansion block.
- Sits between the block padder/loader (upstream) and the compression core (downstream).

---
 rtl/sha256_msg_schedule_pkg.sv | 21 ++
 rtl/SHA256_New_W.sv | 21 ++
 rtl/sha256_msg_schedule.sv | 93 +++++++++
 tb/tb_sha256_msg_schedule.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_msg_schedule_pkg.sv
// Shared definitions for the SHA-256 message-schedule stage: widths, the
// 16-word window type, the schedule FSM encoding and the rotate helper.
package sha256_msg_schedule_pkg;

    localparam int WORD_W    = 32;
    localparam int BLOCK_W   = 512;
    localparam int SCHED_LEN = 16;

    typedef logic [WORD_W-1:0] word_t;
    typedef word_t sched_win_t [0:SCHED_LEN-1];

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_e;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage

// File: rtl/SHA256_New_W.sv
// Combinational SHA-256 schedule expansion:
// new_w = s1(b) + d + s0(a) + c, where s0/s1 are the lower-case sigma functions.
module SHA256_New_W
    import sha256_msg_schedule_pkg::*;
(
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    input  logic [WORD_W-1:0] c_i,
    input  logic [WORD_W-1:0] d_i,
    output logic [WORD_W-1:0] new_w_o
);

    word_t sig0;
    word_t sig1;

    assign sig0    = rotr(a_i, 7)  ^ rotr(a_i, 18) ^ (a_i >> 3);
    assign sig1    = rotr(b_i, 17) ^ rotr(b_i, 19) ^ (b_i >> 10);
    // Modular 32-bit sum; carries out of bit 31 are dropped by the width.
    assign new_w_o = sig1 + d_i + sig0 + c_i;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one 512-bit block into a 16-word sliding
// window and streams W[0..ROUNDS-1] downstream over a valid/ready handshake.
module sha256_msg_schedule
    import sha256_msg_schedule_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] block_in,
    output logic               w_valid,
    input  logic               w_ready,
    output logic [WORD_W-1:0]  w_out,
    output logic [5:0]         w_round,
    output logic               w_last,
    output logic               done
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; valid never depends on ready, ready is a function of state.
    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    sched_state_e state_q, state_d;
    sched_win_t   win_q, win_d;
    logic [5:0]   t_q, t_d;
    logic         done_q, done_d;
    word_t        new_w;
    logic         load;
    logic         advance;
    logic         final_hs;

    SHA256_New_W u_new_w (
        .a_i     (win_q[1]),
        .b_i     (win_q[14]),
        .c_i     (win_q[0]),
        .d_i     (win_q[9]),
        .new_w_o (new_w)
    );

    assign in_ready = (state_q == IDLE);
    assign w_valid  = (state_q == RUN);
    assign w_out    = win_q[0];
    assign w_round  = t_q;
    assign w_last   = w_valid & (t_q == LAST_T);
    assign done     = done_q;

    assign load     = in_valid & in_ready;
    assign advance  = w_valid & w_ready;
    assign final_hs = advance & (t_q == LAST_T);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        t_d     = t_q;
        done_d  = 1'b0;
        if (load) begin
            for (int i = 0; i < SCHED_LEN; i++) begin
                win_d[i] = block_in[BLOCK_W-1-WORD_W*i -: WORD_W];
            end
            t_d     = '0;
            state_d = RUN;
        end else if (advance) begin
            for (int i = 0; i < SCHED_LEN - 1; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[SCHED_LEN-1] = new_w;
            // t stays at ROUNDS-1 on the final word so it never wraps in-block.
            if (final_hs) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                t_d = t_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            win_q   <= '{default: '0};
            t_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            t_q     <= t_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: directed blocks with hand-known words, an
// expected-word queue filled at issue time and drained by independent monitors.
module tb_sha256_msg_schedule;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] ONES_BLK  = {512{1'b1}};
    localparam logic [511:0] OTHER_BLK = {16{32'hDEADBEEF}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         in_valid, in_ready, w_valid, w_ready, w_last, done;
    logic [511:0] block_in;
    logic [31:0]  w_out;
    logic [5:0]   w_round;

    logic         s_in_valid, s_in_ready, s_w_valid, s_w_ready, s_w_last, s_done;
    logic [511:0] s_block_in;
    logic [31:0]  s_w_out;
    logic [5:0]   s_w_round;

    int errors = 0;
    int checks = 0;

    logic [38:0] exp_q[$];
    logic [38:0] s_exp_q[$];
    bit          done_pend = 1'b0;
    bit          s_done_pend = 1'b0;
    logic [31:0] m_w [0:63];

    int ready_mode = 0;
    bit did_stall  = 1'b0;
    int stall_left = 0;

    sha256_msg_schedule #(.ROUNDS(64)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .block_in(block_in), .w_valid(w_valid), .w_ready(w_ready), .w_out(w_out),
        .w_round(w_round), .w_last(w_last), .done(done)
    );

    sha256_msg_schedule #(.ROUNDS(16)) u_dut16 (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .block_in(s_block_in), .w_valid(s_w_valid), .w_ready(s_w_ready), .w_out(s_w_out),
        .w_round(s_w_round), .w_last(s_w_last), .done(s_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule written directly from the FIPS recurrence.
    task automatic build_model(input logic [511:0] blk);
        for (int t = 0; t < 16; t++) m_w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            m_w[t] = (ror(m_w[t-2], 17) ^ ror(m_w[t-2], 19) ^ (m_w[t-2] >> 10))
                   + m_w[t-7]
                   + (ror(m_w[t-15], 7) ^ ror(m_w[t-15], 18) ^ (m_w[t-15] >> 3))
                   + m_w[t-16];
        end
    endtask

    task automatic push_block(input logic [511:0] blk, input bit is_abc);
        logic [31:0] w;
        build_model(blk);
        for (int t = 0; t < 64; t++) begin
            w = m_w[t];
            if (is_abc) begin
                case (t)
                    16: w = 32'h61626380;
                    17: w = 32'h000F0000;
                    18: w = 32'h7DA86405;
                    19: w = 32'h600003C6;
                    63: w = 32'h12B1EDEB;
                    default: ;
                endcase
            end
            exp_q.push_back({(t == 63), 6'(t), w});
        end
    endtask

    task automatic load_block(input logic [511:0] blk, input bit hold, output bit done_at_accept);
        int n;
        n = 0;
        done_at_accept = 1'b0;
        block_in = blk;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("load_timeout", 1, 0);
            in_valid = 1'b0;
            return;
        end
        done_at_accept = done;
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
        check("w_valid_after_load", w_valid, 1);
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) return;
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic wait_round(input logic [5:0] r);
        int n;
        n = 0;
        while (!(w_valid && w_round == r)) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 300) begin
                check("round_timeout", w_round, r);
                return;
            end
        end
    endtask

    // Downstream ready generator: 0 = always ready, 1 = random with a forced
    // 3-cycle stall at t = 20, 2 = left to the main sequence.
    initial begin
        w_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                w_ready = 1'b1;
            end else if (ready_mode == 1) begin
                if (w_valid && w_round == 6'd20 && !did_stall) begin
                    stall_left = 3;
                    did_stall  = 1'b1;
                end
                if (stall_left > 0) begin
                    w_ready = 1'b0;
                    stall_left--;
                end else begin
                    w_ready = ($urandom_range(0, 2) != 0);
                end
            end
        end
    end

    // Monitor for the 64-round instance.
    bit          stall_prev = 1'b0;
    logic [31:0] prev_word;
    logic [5:0]  prev_round;
    always @(negedge clk) begin
        logic [38:0] e;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (done) begin
                check("done_expected", done_pend, 1);
                done_pend = 1'b0;
            end
            if (w_valid && stall_prev) begin
                check("stall_w_out", w_out, prev_word);
                check("stall_w_round", w_round, prev_round);
            end
            if (w_valid && w_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", w_round, 6'h3F);
                end else begin
                    e = exp_q.pop_front();
                    check("w_out", w_out, e[31:0]);
                    check("w_round", w_round, e[37:32]);
                    check("w_last", w_last, e[38]);
                    if (e[38]) done_pend = 1'b1;
                end
            end
            stall_prev = w_valid && !w_ready;
            prev_word  = w_out;
            prev_round = w_round;
        end
    end

    // Monitor for the 16-round instance.
    always @(negedge clk) begin
        logic [38:0] e;
        if (!reset) begin
            if (s_done) begin
                check("r16_done_expected", s_done_pend, 1);
                s_done_pend = 1'b0;
            end
            if (s_w_valid && s_w_ready) begin
                if (s_exp_q.size() == 0) begin
                    check("r16_unexpected_word", s_w_round, 6'h3F);
                end else begin
                    e = s_exp_q.pop_front();
                    check("r16_w_out", s_w_out, e[31:0]);
                    check("r16_w_round", s_w_round, e[37:32]);
                    check("r16_w_last", s_w_last, e[38]);
                    if (e[38]) s_done_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit df;
        int lat;
        logic [511:0] sblk;

        reset = 1'b1;
        in_valid = 1'b0;
        block_in = '0;
        s_in_valid = 1'b0;
        s_block_in = '0;
        s_w_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_w_valid", w_valid, 0);
        check("rst_w_out", w_out, 0);
        check("rst_w_round", w_round, 0);
        check("rst_w_last", w_last, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        // "abc" block, always ready.
        push_block(ABC_BLK, 1'b1);
        load_block(ABC_BLK, 1'b0, df);
        wait_done(200, lat);
        // Load cycle is cycle 0; done lands in cycle 65, i.e. 64 edges later.
        check("done_latency", lat, 64);
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 0);
        check("queue_empty_abc", exp_q.size(), 0);

        // Same block with random stalls and an in_valid pulse during RUN.
        ready_mode = 1;
        did_stall = 1'b0;
        push_block(ABC_BLK, 1'b1);
        load_block(ABC_BLK, 1'b0, df);
        wait_round(6'd10);
        block_in = OTHER_BLK;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(600, lat);
        check("queue_empty_stall", exp_q.size(), 0);
        ready_mode = 0;

        // w_ready toggling while idle must not start anything.
        ready_mode = 2;
        repeat (4) begin
            @(posedge clk);
            #1;
            w_ready = ~w_ready;
            check("idle_no_valid", w_valid, 0);
            check("idle_no_done", done, 0);
        end
        w_ready = 1'b1;
        ready_mode = 0;

        // Back-to-back: second block waits with in_valid high, taken in done cycle.
        push_block(ABC_BLK, 1'b1);
        push_block(ONES_BLK, 1'b0);
        load_block(ABC_BLK, 1'b1, df);
        load_block(ONES_BLK, 1'b0, df);
        check("b2b_accept_in_done_cycle", df, 1);
        check("b2b_first_word", w_out, 32'hFFFFFFFF);
        check("b2b_first_round", w_round, 0);
        wait_done(200, lat);
        check("queue_empty_b2b", exp_q.size(), 0);

        // ROUNDS = 16 build: exactly the input words, then done.
        for (int i = 0; i < 16; i++) begin
            sblk[511-32*i -: 32] = 32'hA5A50000 | 32'(i);
            s_exp_q.push_back({(i == 15), 6'(i), 32'hA5A50000 | 32'(i)});
        end
        s_block_in = sblk;
        s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("r16_done_latency", lat, 16);
        check("r16_no_valid_at_done", s_w_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("r16_stays_idle", s_w_valid, 0);
        check("r16_queue_empty", s_exp_q.size(), 0);

        // Asynchronous reset mid-stream at t = 30.
        push_block(ABC_BLK, 1'b1);
        load_block(ABC_BLK, 1'b0, df);
        wait_round(6'd30);
        #2;
        reset = 1'b1;
        #1;
        check("arst_w_valid", w_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_w_round", w_round, 0);
        check("arst_w_out", w_out, 0);
        exp_q.delete();
        done_pend = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("arst_no_done", done, 0);
        push_block(ABC_BLK, 1'b1);
        load_block(ABC_BLK, 1'b0, df);
        check("arst_restart_round", w_round, 0);
        wait_done(200, lat);
        check("queue_empty_after_reset", exp_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
